// File: rtl/obstacle_scroller.sv
// Three-lane obstacle map for the car game: scrolls one row per SpeedTick edge, spawns
// from an LFSR, scores dodged rows and flags collisions. SCROLL_SPEEDUP_EN enables score-driven SpeedReq.
module obstacle_scroller #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned SCORE_W   = 10,
    parameter int unsigned SPAWN_GAP = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                SpeedTick,
    input  logic                Run,
    input  logic [1:0]          CarLane,
    output logic [3*ROWS-1:0]   ObstacleMap,
    output logic                Collision,
    output logic [SCORE_W-1:0]  Score,
    output logic [2:0]          SpeedReq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HIT
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0]         SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [3:0]         GAP_MIN   = 4'(SPAWN_GAP);

    state_t              state_q, state_d;
    logic [3*ROWS-1:0]   map_q, map_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [3:0]          gap_q, gap_d;
    logic                tick_q;

    logic                step;
    logic                hit;
    logic                spawn;
    logic [2:0]          lane_oh;
    logic [2:0]          bottom;
    logic [2:0]          spawn_row;

    assign step   = SpeedTick ^ tick_q;
    assign bottom = map_q[3*(ROWS-1) +: 3];

    always_comb begin
        case (CarLane)
            2'd0:    lane_oh = 3'b001;
            2'd1:    lane_oh = 3'b010;
            default: lane_oh = 3'b100;
        endcase
    end

    assign hit       = |(bottom & lane_oh);
    assign spawn     = (gap_q >= GAP_MIN) && (lfsr_q[1:0] != 2'b11);
    assign spawn_row = spawn ? (3'b001 << lfsr_q[1:0]) : 3'b000;

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        score_d = score_q;
        lfsr_d  = lfsr_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                map_d   = '0;
                score_d = '0;
                gap_d   = '0;
                if (Run) state_d = S_RUN;
            end
            S_RUN: begin
                if (!Run) begin
                    state_d = S_IDLE;
                    map_d   = '0;
                    score_d = '0;
                    gap_d   = '0;
                end else if (hit) begin
                    // Collision wins over a coincident step: nothing moves.
                    state_d = S_HIT;
                end else if (step) begin
                    map_d  = {map_q[3*(ROWS-1)-1:0], spawn_row};
                    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    if ((bottom != 3'b000) && (score_q != SCORE_MAX)) score_d = score_q + 1'b1;
                    if (spawn)               gap_d = '0;
                    else if (gap_q != 4'hF)  gap_d = gap_q + 4'd1;
                end
            end
            S_HIT: begin
                if (!Run) begin
                    state_d = S_IDLE;
                    map_d   = '0;
                    score_d = '0;
                    gap_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        tick_q <= SpeedTick;
        if (!Resetn) begin
            state_q <= S_IDLE;
            map_q   <= '0;
            score_q <= '0;
            lfsr_q  <= SEED;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
        end
    end

    assign ObstacleMap = map_q;
    assign Score       = score_q;
    assign Collision   = (state_q == S_HIT);

`ifdef SCROLL_SPEEDUP_EN
    logic [2:0] speed_req_q, speed_req_d;

    always_comb begin
        if (32'(score_q) < 32'd16)      speed_req_d = 3'b100;
        else if (32'(score_q) < 32'd48) speed_req_d = 3'b010;
        else                            speed_req_d = 3'b001;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) speed_req_q <= 3'b100;
        else         speed_req_q <= speed_req_d;
    end

    assign SpeedReq = speed_req_q;
`else
    assign SpeedReq = 3'b100;
`endif

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller: a row-array game model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_obstacle_scroller;

    localparam int ROWS      = 8;
    localparam int SCORE_W   = 10;
    localparam int SPAWN_GAP = 2;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    logic                Clock     = 1'b0;
    logic                Resetn    = 1'b0;
    logic                SpeedTick = 1'b0;
    logic                Run       = 1'b0;
    logic [1:0]          CarLane   = 2'd0;
    logic [3*ROWS-1:0]   ObstacleMap;
    logic                Collision;
    logic [SCORE_W-1:0]  Score;
    logic [2:0]          SpeedReq;

    obstacle_scroller #(
        .ROWS      (ROWS),
        .SCORE_W   (SCORE_W),
        .SPAWN_GAP (SPAWN_GAP),
        .LFSR_SEED (8'hA5)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .SpeedTick   (SpeedTick),
        .Run         (Run),
        .CarLane     (CarLane),
        .ObstacleMap (ObstacleMap),
        .Collision   (Collision),
        .Score       (Score),
        .SpeedReq    (SpeedReq)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: rows as an int array, 0 = idle, 1 = playing, 2 = crashed.
    int m_state, m_score, m_gap, m_lfsr, m_tick, m_req;
    int m_map[ROWS];
    bit model_valid = 1'b0;

    function automatic int req_for(input int s);
`ifdef SCROLL_SPEEDUP_EN
        if (s < 16) return 4;
        else if (s < 48) return 2;
        else return 1;
`else
        return 4;
`endif
    endfunction

    function automatic logic [31:0] model_map_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < ROWS; r++) v = v | (32'(m_map[r]) << (3 * r));
        return v;
    endfunction

    function automatic void clear_game();
        for (int r = 0; r < ROWS; r++) m_map[r] = 0;
        m_score = 0;
        m_gap   = 0;
    endfunction

    always @(posedge Clock) begin
        int step, old_score, bottom, lane;
        step      = (int'(SpeedTick) != m_tick);
        m_tick    = int'(SpeedTick);
        old_score = m_score;
        if (!Resetn) begin
            m_state = 0;
            clear_game();
            m_lfsr = 'hA5;
            m_req  = 4;
            model_valid = 1'b1;
        end else begin
            bottom = m_map[ROWS-1];
            lane   = (CarLane == 2'd3) ? 2 : int'(CarLane);
            case (m_state)
                0: begin
                    clear_game();
                    if (Run) m_state = 1;
                end
                1: begin
                    if (!Run) begin
                        m_state = 0;
                        clear_game();
                    end else if ((bottom & (1 << lane)) != 0) begin
                        m_state = 2;
                    end else if (step != 0) begin
                        if (bottom != 0 && m_score < SCORE_MAX) m_score++;
                        for (int r = ROWS - 1; r > 0; r--) m_map[r] = m_map[r-1];
                        if (m_gap >= SPAWN_GAP && (m_lfsr & 3) != 3) begin
                            m_map[0] = 1 << (m_lfsr & 3);
                            m_gap = 0;
                        end else begin
                            m_map[0] = 0;
                            if (m_gap < 15) m_gap++;
                        end
                        m_lfsr = ((m_lfsr << 1) & 'hFF) | int'(^(m_lfsr & 'hB8));
                    end
                end
                default: begin
                    if (!Run) begin
                        m_state = 0;
                        clear_game();
                    end
                end
            endcase
            m_req = req_for(old_score);
        end
    end

    always @(negedge Clock) begin
        if (model_valid) begin
            chk("cyc_map",  32'(ObstacleMap), model_map_vec());
            chk("cyc_score", 32'(Score), 32'(m_score));
            chk("cyc_coll", 32'(Collision), 32'(m_state == 2));
            chk("cyc_req",  32'(SpeedReq), 32'(m_req));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    task automatic toggle();
        SpeedTick = ~SpeedTick;
        cyc(1);
    endtask

    function automatic int safe_lane();
        for (int l = 0; l < 3; l++) if (((m_map[ROWS-1] >> l) & 1) == 0) return l;
        return 0;
    endfunction

    int alt = 0;
    task automatic dodge_step();
        int l;
        l = safe_lane();
        alt++;
        CarLane = (l == 2 && alt[0]) ? 2'd3 : 2'(l);
        toggle();
    endtask

    function automatic bit gaps_ok(input logic [3*ROWS-1:0] v);
        int last = -1;
        logic [2:0] row;
        for (int r = 0; r < ROWS; r++) begin
            row = v[3*r +: 3];
            if (row != 3'b000) begin
                if (row != 3'b001 && row != 3'b010 && row != 3'b100) return 1'b0;
                if (last >= 0 && (r - last - 1) < SPAWN_GAP) return 1'b0;
                last = r;
            end
        end
        return 1'b1;
    endfunction

    task automatic advance_to_bottom(output int lane, output bit ok);
        ok = 1'b0;
        lane = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (m_map[ROWS-1] != 0) begin
                ok = 1'b1;
                lane = (m_map[ROWS-1] == 1) ? 0 : (m_map[ROWS-1] == 2) ? 1 : 2;
            end else begin
                dodge_step();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lane;
        bit ok;
        logic [31:0] saved_map;
        int saved_score;

        cyc(3);
        chk("rst_map",   32'(ObstacleMap), 32'h0);
        chk("rst_score", 32'(Score), 32'h0);
        chk("rst_coll",  32'(Collision), 32'h0);
        chk("rst_req",   32'(SpeedReq), 32'h4);
        Resetn = 1'b1;
        cyc(1);

        // First steps from seed A5: two empty rows, then lane 1 spawns and scrolls.
        Run = 1'b1;
        cyc(1);
        toggle();
        chk("t1_row0_empty", 32'(ObstacleMap), 32'h0);
        chk("t1_score",      32'(Score), 32'h0);
        chk("t1_coll",       32'(Collision), 32'h0);
        toggle();
        chk("t1_second_empty", 32'(ObstacleMap), 32'h0);
        toggle();
        chk("t1_first_spawn", 32'(ObstacleMap), 32'h000002);
        cyc(2);
        chk("t1_no_step_hold", 32'(ObstacleMap), 32'h000002);
        toggle();
        chk("t1_shift", 32'(ObstacleMap), 32'h000010);

        for (int i = 0; i < 40; i++) begin
            dodge_step();
            chk("t2_gaps", 32'(gaps_ok(ObstacleMap)), 32'h1);
            if (i % 7 == 3) cyc(1);
        end

        // Collision without a coincident step.
        advance_to_bottom(lane, ok);
        chk("t3_reach", 32'(ok), 32'h1);
        saved_map   = model_map_vec();
        saved_score = m_score;
        CarLane = (lane == 2) ? 2'd3 : 2'(lane);
        cyc(1);
        chk("t3_coll",  32'(Collision), 32'h1);
        chk("t3_map",   32'(ObstacleMap), saved_map);
        chk("t3_score", 32'(Score), 32'(saved_score));
        repeat (3) toggle();
        chk("t3_frozen_map",   32'(ObstacleMap), saved_map);
        chk("t3_frozen_score", 32'(Score), 32'(saved_score));
        chk("t3_still_hit",    32'(Collision), 32'h1);
        Run = 1'b0;
        cyc(1);
        chk("t3_idle_map",   32'(ObstacleMap), 32'h0);
        chk("t3_idle_score", 32'(Score), 32'h0);
        chk("t3_idle_coll",  32'(Collision), 32'h0);

        // Collision on the same cycle as a step.
        Run = 1'b1;
        cyc(1);
        advance_to_bottom(lane, ok);
        chk("t4_reach", 32'(ok), 32'h1);
        saved_map   = model_map_vec();
        saved_score = m_score;
        CarLane   = 2'(lane);
        SpeedTick = ~SpeedTick;
        cyc(1);
        chk("t4_coll",  32'(Collision), 32'h1);
        chk("t4_map",   32'(ObstacleMap), saved_map);
        chk("t4_score", 32'(Score), 32'(saved_score));
        Run = 1'b0;
        cyc(1);
        chk("t4_idle_map", 32'(ObstacleMap), 32'h0);

        // Long game to score saturation.
        Run = 1'b1;
        cyc(1);
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            dodge_step();
            if (m_score == SCORE_MAX) ok = 1'b1;
        end
        chk("t5_reached_max", 32'(ok), 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (m_map[ROWS-1] != 0) ok = 1'b1;
            dodge_step();
        end
        chk("t5_dodge_at_max", 32'(ok), 32'h1);
        cyc(1);
        chk("t5_saturated", 32'(Score), 32'h3FF);
`ifdef SCROLL_SPEEDUP_EN
        chk("t5_req_fast", 32'(SpeedReq), 32'h1);
`else
        chk("t5_req_fixed", 32'(SpeedReq), 32'h4);
`endif

        // Reset in the middle of a game restarts the LFSR from its seed.
        while (m_map[ROWS-1] != 0 || model_map_vec() == 0) dodge_step();
        Resetn = 1'b0;
        cyc(1);
        chk("t6_map",   32'(ObstacleMap), 32'h0);
        chk("t6_score", 32'(Score), 32'h0);
        chk("t6_coll",  32'(Collision), 32'h0);
        chk("t6_req",   32'(SpeedReq), 32'h4);
        Resetn  = 1'b1;
        CarLane = 2'd0;
        cyc(1);
        cyc(1);
        toggle();
        toggle();
        toggle();
        chk("t6_reseed_spawn", 32'(ObstacleMap), 32'h000002);
        toggle();
        chk("t6_reseed_shift", 32'(ObstacleMap), 32'h000010);
        Run = 1'b0;
        cyc(1);
        chk("t6_abort_map", 32'(ObstacleMap), 32'h0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
